// File: rtl/audio_pkg.sv
// Shared audio-path types used by the delay/divide stage and the moving-average filter.
package audio_pkg;
   localparam int SAMPLE_W = 24;
   typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/sample_ring_buf.sv
// Circular store of the last N scaled samples; presents the entry about to be overwritten.
module sample_ring_buf #(
   parameter int DATA_W = 24,
   parameter int LOG2_N = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic signed [DATA_W-1:0] wdata,
   output logic signed [DATA_W-1:0] rdata
);
   localparam int N = 1 << LOG2_N;

   logic signed [DATA_W-1:0] mem_r [N];
   logic [LOG2_N-1:0]        ptr_r;

   // Entry storage and write pointer; the pointer wraps naturally at N-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            mem_r[i] <= '0;
         end
         ptr_r <= '0;
      end else if (we) begin
         mem_r[ptr_r] <= wdata;
         ptr_r        <= ptr_r + LOG2_N'(1);
      end
   end

   assign rdata = mem_r[ptr_r];
endmodule

// File: rtl/running_avg_filter.sv
// N-point moving average: each sample is pre-divided by N and summed over a sliding window.
module running_avg_filter
   import audio_pkg::*;
#(
   parameter int DATA_W = SAMPLE_W,
   parameter int LOG2_N = 3
) (
   input  logic                     Clock,
   input  logic                     reset_n,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     primed
);
   localparam int                       N     = 1 << LOG2_N;
   localparam logic signed [DATA_W-1:0] WIN_N = DATA_W'(N);
   localparam logic [LOG2_N:0]          FULL  = (LOG2_N + 1)'(N);

   logic signed [DATA_W-1:0] scaled_s;
   logic signed [DATA_W-1:0] evict_s;
   logic signed [DATA_W-1:0] acc_next_s;
   logic [LOG2_N:0]          cnt_next_s;
   logic signed [DATA_W-1:0] acc_r;
   logic signed [DATA_W-1:0] data_r;
   logic [LOG2_N:0]          cnt_r;
   logic                     valid_r;
   logic                     primed_r;

   sample_ring_buf #(
      .DATA_W (DATA_W),
      .LOG2_N (LOG2_N)
   ) u_ring (
      .clk   (Clock),
      .rst_n (reset_n),
      .we    (in_valid),
      .wdata (scaled_s),
      .rdata (evict_s)
   );

   // Signed division truncates toward zero; the sum of N scaled terms cannot overflow DATA_W.
   always_comb begin
      scaled_s   = in_data / WIN_N;
      acc_next_s = acc_r;
      cnt_next_s = cnt_r;
      if (in_valid) begin
         acc_next_s = acc_r + scaled_s - evict_s;
         if (cnt_r != FULL) begin
            cnt_next_s = cnt_r + (LOG2_N + 1)'(1);
         end else begin
            cnt_next_s = cnt_r;
         end
      end else begin
         acc_next_s = acc_r;
      end
   end

   // Accumulator, fill counter and output registers.
   always_ff @(posedge Clock or negedge reset_n) begin
      if (!reset_n) begin
         acc_r    <= '0;
         data_r   <= '0;
         cnt_r    <= '0;
         valid_r  <= 1'b0;
         primed_r <= 1'b0;
      end else begin
         valid_r  <= in_valid;
         cnt_r    <= cnt_next_s;
         primed_r <= (cnt_next_s == FULL);
         if (in_valid) begin
            acc_r  <= acc_next_s;
            data_r <= acc_next_s;
         end
      end
   end

   assign out_valid = valid_r;
   assign out_data  = data_r;
   assign primed    = primed_r;
endmodule

// File: tb/tb_running_avg_filter.sv
// Directed plus randomized check of running_avg_filter against a sliding-window queue model.
module tb_running_avg_filter;
   localparam int DATA_W = 24;
   localparam int LOG2_N = 3;
   localparam int N      = 8;

   logic                     Clock    = 1'b0;
   logic                     reset_n  = 1'b0;
   logic                     in_valid = 1'b0;
   logic signed [DATA_W-1:0] in_data  = '0;
   logic                     out_valid;
   logic signed [DATA_W-1:0] out_data;
   logic                     primed;

   int checks   = 0;
   int errors   = 0;
   int win[$];
   int accepted = 0;
   int exp_data = 0;

   running_avg_filter #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) dut (
      .Clock     (Clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .primed    (primed)
   );

   always #5 Clock = ~Clock;

   function automatic int scale(input logic signed [DATA_W-1:0] d);
      int v;
      v = d;
      return v / N;
   endfunction

   task automatic check_outs(input string tag, input logic exp_valid);
      logic signed [DATA_W-1:0] e;
      logic                     p;
      e = DATA_W'(exp_data);
      p = (accepted >= N);
      checks++;
      assert (out_valid === exp_valid) else begin
         errors++;
         $error("FAIL %s out_valid got %0b expected %0b", tag, out_valid, exp_valid);
      end
      checks++;
      assert (out_data === e) else begin
         errors++;
         $error("FAIL %s out_data got %0d expected %0d", tag, out_data, e);
      end
      checks++;
      assert (primed === p) else begin
         errors++;
         $error("FAIL %s primed got %0b expected %0b", tag, primed, p);
      end
   endtask

   task automatic expect_data(input string tag, input int val);
      logic signed [DATA_W-1:0] e;
      e = DATA_W'(val);
      checks++;
      assert (out_data === e) else begin
         errors++;
         $error("FAIL %s out_data got %0d expected %0d", tag, out_data, e);
      end
   endtask

   task automatic step(input string tag, input logic v, input logic signed [DATA_W-1:0] d);
      @(negedge Clock);
      in_valid = v;
      in_data  = d;
      @(posedge Clock);
      #1;
      if (v) begin
         win.push_back(scale(d));
         if (win.size() > N) void'(win.pop_front());
         accepted++;
         exp_data = win.sum();
      end
      check_outs(tag, v);
   endtask

   task automatic do_reset(input string tag);
      @(negedge Clock);
      #2 reset_n = 1'b0;
      #1;
      win.delete();
      accepted = 0;
      exp_data = 0;
      check_outs(tag, 1'b0);
      @(negedge Clock);
      in_valid = 1'b0;
      reset_n  = 1'b1;
   endtask

   initial begin
      logic signed [DATA_W-1:0] d;
      #3;
      check_outs("por", 1'b0);
      @(negedge Clock);
      reset_n = 1'b1;

      for (int i = 1; i <= 10; i++) begin
         step("step", 1'b1, 24'sd80);
         expect_data("step_const", (i < N ? i : N) * 10);
      end
      do_reset("rst_mid");

      for (int i = 0; i < 10; i++) begin
         step("impulse", 1'b1, (i == 0) ? 24'sd800 : 24'sd0);
         expect_data("impulse_const", (i < N) ? 100 : 0);
      end
      do_reset("rst2");

      step("neg7", 1'b1, -24'sd7);
      expect_data("neg7_const", 0);
      step("neg8", 1'b1, -24'sd8);
      expect_data("neg8_const", -1);
      do_reset("rst3");
      for (int i = 0; i < N; i++) step("maxpos", 1'b1, 24'h7FFFFF);
      expect_data("maxpos_const", 8388600);
      do_reset("rst4");

      step("gap_a", 1'b1, 24'sd80);
      for (int i = 0; i < 3; i++) begin
         step("gap_idle", 1'b0, 24'sd555);
         expect_data("gap_hold", 10);
      end
      step("gap_b", 1'b1, 24'sd80);
      expect_data("gap_const", 20);
      do_reset("rst5");

      for (int i = 0; i < 4; i++) step("pre_rst", 1'b1, 24'sd80);
      expect_data("pre_rst_const", 40);
      do_reset("rst6");
      step("post_rst", 1'b1, 24'sd80);
      expect_data("post_rst_const", 10);
      for (int i = 0; i < N; i++) step("refill", 1'b1, 24'sd80);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            do_reset("rnd_rst");
         end else begin
            case ($urandom_range(0, 5))
               0:       d = 24'h800000;
               1:       d = 24'h7FFFFF;
               default: d = DATA_W'($urandom);
            endcase
            step("rnd", ($urandom_range(0, 3) != 0), d);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
